regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter N, default 8: register width in bits.
REQ-002 Parameter R, default 32: number of registers, legal range 2..256, not necessarily a power of two.
REQ-003 Parameter RP, default 2: number of independent read ports, legal range 1..4.
REQ-004 Parameter ZERO_REG, default 0: when 1, register 0 always reads 0 and ignores writes.
REQ-005 Derived RR = $clog2(R): address width.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-008 data_in  input  N  write data.
REQ-009 reg_id_w  input  RR  write address.
REQ-010 wr  input  1  write enable.
REQ-011 reg_id_r  input  RP*RR  read addresses; port k occupies bits [k*RR +: RR].
REQ-012 rd_en  input  RP  per-port read enable.
REQ-013 clr  input  1  single-cycle request to start a full-array clear sweep.
REQ-014 data_out  output  RP*N  read data; port k occupies bits [k*N +: N].
REQ-015 rd_valid  output  RP  per-port pulse; data_out slice is valid while it is high.
REQ-016 busy  output  1  high while a clear sweep is in progress.
REQ-017 wr_err  output  1  one-cycle pulse flagging a rejected write.

Function
REQ-018 FSM has two states: IDLE and CLEAR; sweep index register idx is RR bits wide.
REQ-019 IDLE with wr=1, clr=0, reg_id_w<R (and not reg 0 when ZERO_REG=1): array[reg_id_w] <= data_in at the edge.
REQ-020 Write to reg_id_w>=R: array unchanged; wr_err=1 for the following cycle.
REQ-021 Write to reg 0 with ZERO_REG=1: silently ignored; wr_err stays 0.
REQ-022 Read latency is 1 cycle: rd_en[k]=1 at edge t gives data_out[k] and rd_valid[k]=1 during cycle t+1.
REQ-023 rd_en[k]=0: rd_valid[k]=0 next cycle; data_out[k] holds its previous value.
REQ-024 Bypass: an accepted same-edge write with reg_id_w equal to reg_id_r[k] returns data_in, not the old contents.
REQ-025 Read of address>=R, or of reg 0 with ZERO_REG=1, returns 0 with rd_valid=1.
REQ-026 All RP ports operate independently; identical addresses on several ports return identical data.
REQ-027 IDLE with clr=1: enter CLEAR, set idx=0, busy=1 from the next cycle; a same-edge wr is dropped and wr_err pulses.
REQ-028 CLEAR: each edge writes 0 to array[idx] and increments idx; the edge writing idx=R-1 returns to IDLE, so busy stays high exactly R cycles.
REQ-029 CLEAR: wr is dropped with wr_err pulse; clr is ignored; rd_en is ignored and rd_valid stays 0.
REQ-030 The first cycle after busy falls accepts writes and reads normally; the whole array reads 0.

Reset
REQ-031 rst=0 immediately, without clk: all registers 0, data_out=0, rd_valid=0, busy=0, wr_err=0, state IDLE, idx=0.
REQ-032 rst asserted mid-sweep aborts the sweep; after release the FSM is in IDLE with busy=0.
REQ-033 rst is released synchronously to the design by the environment; no write or read is accepted while rst=0.

Verification
REQ-034 Default params: write i^8'hA5 to regs 0..31, then read port0 = 5 and port1 = 31 -> data_out = {8'hBA, 8'hA0}, rd_valid=2'b11 one cycle later.
REQ-035 Same edge: wr=1, reg_id_w=7, data_in=8'h3C with port0 reading reg 7 -> port0 returns 8'h3C (bypass); the reg 7 read on the next edge also returns 8'h3C.
REQ-036 Pulse clr with array full -> busy high for exactly 32 cycles; a write during busy gives wr_err=1 and no change; after busy falls all 32 regs read 8'h00.
REQ-037 R=20: write 8'hFF to address 25 -> wr_err pulses one cycle; read of address 25 returns 8'h00 with rd_valid=1.
REQ-038 ZERO_REG=1: write 8'h55 to reg 0 -> wr_err=0 and reg 0 reads 8'h00; a write to reg 1 reads back 8'h55.
REQ-039 Assert rst at cycle 10 of a sweep, without a clock edge -> all outputs 0 at once; after release, busy=0 and reads return 0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, write-error flag and clear sweep
// Reads are registered; a clear sweep zeroes one register per cycle while busy is high.
module regfile_mp #(
   parameter  int N        = 8,
   parameter  int R        = 32,
   parameter  int RP       = 2,
   parameter  int ZERO_REG = 0,
   localparam int RR       = $clog2(R)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    data_in,
   input  logic [RR-1:0]   reg_id_w,
   input  logic            wr,
   input  logic [RP*RR-1:0] reg_id_r,
   input  logic [RP-1:0]   rd_en,
   input  logic            clr,
   output logic [RP*N-1:0] data_out,
   output logic [RP-1:0]   rd_valid,
   output logic            busy,
   output logic            wr_err
);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   localparam logic [RR:0]   R_LIM    = (RR+1)'(R);
   localparam logic [RR-1:0] LAST_IDX = RR'(R - 1);

   state_t          state_q, state_d;
   logic [RR-1:0]   idx_q, idx_d;
   logic [N-1:0]    mem_q [R];
   logic [N-1:0]    mem_d [R];
   logic [RP*N-1:0] dout_q, dout_d;
   logic [RP-1:0]   vld_q, vld_d;
   logic            err_q, err_d;

   logic            wr_in_range;
   logic            wr_zero;
   logic            wr_ok;
   logic [N-1:0]    rd_word [RP];

   assign wr_in_range = ({1'b0, reg_id_w} < R_LIM);
   assign wr_zero     = (ZERO_REG != 0) && (reg_id_w == '0);
   assign wr_ok       = (state_q == S_IDLE) && wr && !clr && wr_in_range && !wr_zero;

   // Each port sees the accepted same-edge write ahead of the stored contents.
   for (genvar k = 0; k < RP; k++) begin : g_rd
      logic [RR-1:0] rd_addr;
      logic          rd_zero;
      assign rd_addr = reg_id_r[k*RR +: RR];
      assign rd_zero = ({1'b0, rd_addr} >= R_LIM) || ((ZERO_REG != 0) && (rd_addr == '0));
      assign rd_word[k] = rd_zero                       ? '0      :
                          (wr_ok && reg_id_w == rd_addr) ? data_in :
                                                           mem_q[rd_addr];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mem_d   = mem_q;
      dout_d  = dout_q;
      vld_d   = '0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            err_d = wr && (clr || !wr_in_range);
            for (int k = 0; k < RP; k++) begin
               if (rd_en[k]) begin
                  vld_d[k]          = 1'b1;
                  dout_d[k*N +: N]  = rd_word[k];
               end
            end
            if (wr_ok) begin
               mem_d[reg_id_w] = data_in;
            end
            if (clr) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end
         end
         S_CLEAR: begin
            err_d        = wr;
            mem_d[idx_q] = '0;
            if (idx_q == LAST_IDX) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         dout_q  <= '0;
         vld_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < R; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         mem_q   <= mem_d;
      end
   end

   assign data_out = dout_q;
   assign rd_valid = vld_q;
   assign busy     = (state_q == S_CLEAR);
   assign wr_err   = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench driving a default instance and an R=20/ZERO_REG=1 instance
// Both instances share stimulus; a behavioural model predicts every output cycle by cycle.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic [7:0]  data_in;
   logic [4:0]  reg_id_w;
   logic        wr;
   logic [9:0]  reg_id_r;
   logic [1:0]  rd_en;
   logic        clr;

   logic [15:0] dout_w [2];
   logic [1:0]  vld_w  [2];
   logic        busy_w [2];
   logic        err_w  [2];

   regfile_mp dut (
      .clk(clk), .rst(rst), .data_in(data_in), .reg_id_w(reg_id_w), .wr(wr),
      .reg_id_r(reg_id_r), .rd_en(rd_en), .clr(clr),
      .data_out(dout_w[0]), .rd_valid(vld_w[0]), .busy(busy_w[0]), .wr_err(err_w[0])
   );

   regfile_mp #(.R(20), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst(rst), .data_in(data_in), .reg_id_w(reg_id_w), .wr(wr),
      .reg_id_r(reg_id_r), .rd_en(rd_en), .clr(clr),
      .data_out(dout_w[1]), .rd_valid(vld_w[1]), .busy(busy_w[1]), .wr_err(err_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0][15:0] dout;
      logic [1:0][1:0]  vld;
      logic [1:0]       busy;
      logic [1:0]       err;
   } snap_t;

   snap_t sb [$];

   int n_checks = 0;
   int n_pass   = 0;

   int          r_of [2] = '{32, 20};
   bit          z_of [2] = '{1'b0, 1'b1};
   logic [7:0]  m_mem  [2][32];
   bit          m_busy [2];
   int          m_idx  [2];
   logic [15:0] m_dout [2];
   logic [1:0]  m_vld  [2];
   bit          m_err  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 32; a++) m_mem[i][a] = 8'h00;
         m_busy[i] = 1'b0;
         m_idx[i]  = 0;
         m_dout[i] = 16'h0;
         m_vld[i]  = 2'b00;
         m_err[i]  = 1'b0;
      end
   endtask

   // Drive one cycle of stimulus, advance the model, and queue the outputs expected after the edge.
   task automatic step(input bit w, input int wa, input logic [7:0] din, input bit c,
                       input int ra0, input int ra1, input logic [1:0] re);
      int    ra [2];
      bit    acc;
      snap_t s;
      ra[0] = ra0;
      ra[1] = ra1;
      wr = w; reg_id_w = 5'(wa); data_in = din; clr = c;
      reg_id_r = {5'(ra1), 5'(ra0)}; rd_en = re;
      for (int i = 0; i < 2; i++) begin
         if (m_busy[i]) begin
            m_err[i] = w;
            m_vld[i] = 2'b00;
            m_mem[i][m_idx[i]] = 8'h00;
            if (m_idx[i] == r_of[i] - 1) begin
               m_busy[i] = 1'b0;
               m_idx[i]  = 0;
            end else begin
               m_idx[i]++;
            end
         end else begin
            acc = w && !c && (wa < r_of[i]) && !(z_of[i] && wa == 0);
            m_err[i] = w && (c || wa >= r_of[i]);
            m_vld[i] = re;
            for (int k = 0; k < 2; k++) begin
               if (re[k]) begin
                  if (ra[k] >= r_of[i] || (z_of[i] && ra[k] == 0)) m_dout[i][k*8 +: 8] = 8'h00;
                  else if (acc && wa == ra[k])                      m_dout[i][k*8 +: 8] = din;
                  else                                              m_dout[i][k*8 +: 8] = m_mem[i][ra[k]];
               end
            end
            if (acc) m_mem[i][wa] = din;
            if (c) begin
               m_busy[i] = 1'b1;
               m_idx[i]  = 0;
            end
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         s.dout[i] = m_dout[i];
         s.vld[i]  = m_vld[i];
         s.busy[i] = m_busy[i];
         s.err[i]  = m_err[i];
      end
      sb.push_back(s);
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 0, 8'h00, 1'b0, 0, 0, 2'b00);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      sb.delete();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_dout%0d", i), dout_w[i], 16'h0);
         chk($sformatf("rst_vld%0d", i),  vld_w[i],  2'b00);
         chk($sformatf("rst_busy%0d", i), busy_w[i], 1'b0);
         chk($sformatf("rst_err%0d", i),  err_w[i],  1'b0);
      end
      model_reset();
      wr = 1'b0; clr = 1'b0; rd_en = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      snap_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("dout%0d", i), dout_w[i], e.dout[i]);
            chk($sformatf("vld%0d", i),  vld_w[i],  e.vld[i]);
            chk($sformatf("busy%0d", i), busy_w[i], e.busy[i]);
            chk($sformatf("err%0d", i),  err_w[i],  e.err[i]);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b0; wr = 1'b0; clr = 1'b0; rd_en = 2'b00;
      data_in = 8'h00; reg_id_w = 5'd0; reg_id_r = 10'd0;
      do_reset();

      for (int i = 0; i < 32; i++) step(1'b1, i, 8'(i ^ 'hA5), 1'b0, 0, 0, 2'b00);

      step(1'b0, 0, 8'h00, 1'b0, 5, 31, 2'b11);
      chk("ports_5_31", dout_w[0], 16'hBAA0);
      chk("ports_vld", vld_w[0], 2'b11);
      chk("oor_read_z", dout_w[1][15:8], 8'h00);

      step(1'b1, 7, 8'h3C, 1'b0, 7, 0, 2'b01);
      chk("bypass", dout_w[0][7:0], 8'h3C);
      step(1'b0, 0, 8'h00, 1'b0, 7, 0, 2'b01);
      chk("after_bypass", dout_w[0][7:0], 8'h3C);

      step(1'b1, 25, 8'hFF, 1'b0, 0, 0, 2'b00);
      chk("oor_wr_err", err_w[1], 1'b1);
      step(1'b0, 0, 8'h00, 1'b0, 25, 25, 2'b11);
      chk("oor_err_pulse", err_w[1], 1'b0);
      chk("oor_rd", dout_w[1], 16'h0000);
      chk("oor_rd_vld", vld_w[1], 2'b11);

      step(1'b1, 0, 8'h55, 1'b0, 0, 0, 2'b00);
      chk("zero_wr_err", err_w[1], 1'b0);
      step(1'b1, 1, 8'h55, 1'b0, 0, 0, 2'b01);
      chk("zero_rd", dout_w[1][7:0], 8'h00);
      step(1'b0, 0, 8'h00, 1'b0, 1, 1, 2'b11);
      chk("reg1_rd", dout_w[1], 16'h5555);

      for (int i = 0; i < 30; i++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 31), 8'($urandom), 1'b0,
              $urandom_range(0, 31), $urandom_range(0, 31), 2'($urandom_range(0, 3)));

      for (int i = 0; i < 32; i++) step(1'b1, i, 8'(i + 1), 1'b0, 0, 0, 2'b00);
      step(1'b1, 4, 8'h99, 1'b1, 0, 0, 2'b00);
      chk("clr_wr_err", err_w[0], 1'b1);
      n = 0;
      while (busy_w[0] && n < 100) begin
         n++;
         step(1'($urandom_range(0, 1)), $urandom_range(0, 31), 8'($urandom), 1'b0,
              $urandom_range(0, 31), $urandom_range(0, 31), 2'b11);
      end
      chk("busy_len", n, 32);
      step(1'b1, 3, 8'h77, 1'b0, 2, 3, 2'b11);
      chk("post_clr_bypass", dout_w[0], 16'h7700);
      for (int j = 0; j < 16; j++) step(1'b0, 0, 8'h00, 1'b0, 2*j, 2*j + 1, 2'b11);

      for (int i = 0; i < 8; i++) step(1'b1, i + 8, 8'hC0 + 8'(i), 1'b0, 0, 0, 2'b00);
      step(1'b0, 0, 8'h00, 1'b1, 0, 0, 2'b00);
      for (int i = 0; i < 9; i++) idle_step();
      do_reset();
      chk("post_rst_busy", busy_w[0], 1'b0);
      for (int j = 4; j < 8; j++) step(1'b0, 0, 8'h00, 1'b0, 2*j, 2*j + 1, 2'b11);

      idle_step();
      @(negedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
